// File: rtl/mul_pkg.sv
// Shared types and default widths for the two-port multiply arbiter.
package mul_pkg;

  localparam int WORD_SIZE_DFLT = 18;
  localparam int SHIFT_W_DFLT   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// One requester's request/result handshake bundle; master is the requester, slave the arbiter.
interface mul_arbiter_if #(
  parameter int WORD_SIZE = 18,
  parameter int SHIFT_W   = 5
);

  logic                 valid;
  logic                 ready;
  logic [WORD_SIZE-1:0] r0;
  logic [WORD_SIZE-1:0] r1;
  logic [SHIFT_W-1:0]   shift;
  logic                 res_valid;
  logic                 res_ready;
  logic [WORD_SIZE-1:0] res;

  modport master (
    output valid, r0, r1, shift, res_ready,
    input  ready, res_valid, res
  );

  modport slave (
    input  valid, r0, r1, shift, res_ready,
    output ready, res_valid, res
  );

endinterface

// File: rtl/mulxx.sv
// Combinational signed multiply followed by a logical right shift that selects a word-wide field.
module mulxx
  import mul_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DFLT,
  parameter int SHIFT_W   = SHIFT_W_DFLT
) (
  input  logic signed [WORD_SIZE-1:0] r0,
  input  logic signed [WORD_SIZE-1:0] r1,
  input  logic        [SHIFT_W-1:0]   shift,
  output logic        [WORD_SIZE-1:0] res
);

  // Bits shifted in above the product MSB are zero, never sign copies.
  function automatic logic [WORD_SIZE-1:0] take_field(
    input logic signed [2*WORD_SIZE-1:0] prod,
    input logic        [SHIFT_W-1:0]     sh
  );
    logic [2*WORD_SIZE-1:0] u;
    u = prod;
    u = u >> sh;
    return u[WORD_SIZE-1:0];
  endfunction

  logic signed [2*WORD_SIZE-1:0] prod;

  assign prod = r0 * r1;
  assign res  = take_field(prod, shift);

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one mulxx between requesters A and B; each result is held until its owner takes it.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DFLT,
  parameter int SHIFT_W   = SHIFT_W_DFLT
) (
  input  logic          clock,
  input  logic          reset,
  mul_arbiter_if.slave  a,
  mul_arbiter_if.slave  b
);

  state_t  state;
  req_id_t last_grant;
  req_id_t owner;

  logic signed [WORD_SIZE-1:0] r0_p0;
  logic signed [WORD_SIZE-1:0] r1_p0;
  logic        [SHIFT_W-1:0]   shift_p0;
  logic        [WORD_SIZE-1:0] mul_res;

  logic [WORD_SIZE-1:0] a_res_p1;
  logic [WORD_SIZE-1:0] b_res_p1;
  logic                 a_vld_p1;
  logic                 b_vld_p1;

  logic pick_a;
  logic pick_b;
  logic owner_take;
  logic can_grant;
  logic a_fire;
  logic b_fire;

  // A grant is possible from IDLE, or from HOLD in the same cycle the owner drains its result.
  always_comb begin
    pick_a     = a.valid && (!b.valid || last_grant == REQ_B);
    pick_b     = b.valid && (!a.valid || last_grant == REQ_A);
    owner_take = (owner == REQ_A) ? a.res_ready : b.res_ready;
    can_grant  = !reset && ((state == IDLE) || (state == HOLD && owner_take));
    a_fire     = can_grant && pick_a;
    b_fire     = can_grant && pick_b;
  end

  assign a.ready     = a_fire;
  assign b.ready     = b_fire;
  assign a.res       = a_res_p1;
  assign b.res       = b_res_p1;
  assign a.res_valid = a_vld_p1;
  assign b.res_valid = b_vld_p1;

  mulxx #(
    .WORD_SIZE (WORD_SIZE),
    .SHIFT_W   (SHIFT_W)
  ) u_mulxx (
    .r0    (r0_p0),
    .r1    (r1_p0),
    .shift (shift_p0),
    .res   (mul_res)
  );

  // Stage p0: operand capture on grant
  always_ff @(posedge clock) begin
    if (a_fire) begin
      r0_p0    <= a.r0;
      r1_p0    <= a.r1;
      shift_p0 <= a.shift;
    end else if (b_fire) begin
      r0_p0    <= b.r0;
      r1_p0    <= b.r1;
      shift_p0 <= b.shift;
    end
  end

  // Stage p1: FSM and per-port result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_B;
      owner      <= REQ_A;
      a_vld_p1   <= 1'b0;
      b_vld_p1   <= 1'b0;
      a_res_p1   <= '0;
      b_res_p1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_fire || b_fire) begin
            owner      <= a_fire ? REQ_A : REQ_B;
            last_grant <= a_fire ? REQ_A : REQ_B;
            state      <= CALC;
          end
        end
        CALC: begin
          if (owner == REQ_A) begin
            a_res_p1 <= mul_res;
            a_vld_p1 <= 1'b1;
          end else begin
            b_res_p1 <= mul_res;
            b_vld_p1 <= 1'b1;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (owner_take) begin
            if (owner == REQ_A) a_vld_p1 <= 1'b0;
            else                b_vld_p1 <= 1'b0;
            if (a_fire || b_fire) begin
              owner      <= a_fire ? REQ_A : REQ_B;
              last_grant <= a_fire ? REQ_A : REQ_B;
              state      <= CALC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: latency, signed/shift arithmetic, round-robin, backpressure, reset.
module tb_mul_arbiter;

  localparam int W  = 18;
  localparam int SW = 5;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  mul_arbiter_if #(.WORD_SIZE(W), .SHIFT_W(SW)) a_if ();
  mul_arbiter_if #(.WORD_SIZE(W), .SHIFT_W(SW)) b_if ();

  mul_arbiter #(.WORD_SIZE(W), .SHIFT_W(SW)) dut (
    .clock (clock),
    .reset (reset),
    .a     (a_if),
    .b     (b_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Raise valid, wait (bounded) for ready, hold through the accepting edge, then drop valid.
  task automatic issue(input bit side, input logic [W-1:0] r0, input logic [W-1:0] r1,
                       input logic [SW-1:0] sh);
    bit got;
    got = 1'b0;
    if (!side) begin
      a_if.valid = 1'b1; a_if.r0 = r0; a_if.r1 = r1; a_if.shift = sh;
    end else begin
      b_if.valid = 1'b1; b_if.r0 = r0; b_if.r1 = r1; b_if.shift = sh;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((!side && a_if.ready) || (side && b_if.ready)) got = 1'b1;
      else tick();
    end
    chk(side ? "b_grant" : "a_grant", 32'(got), 32'd1);
    tick();
    if (!side) a_if.valid = 1'b0;
    else       b_if.valid = 1'b0;
  endtask

  // Single transaction with exact latency: result valid one edge after the accept edge.
  task automatic run(input bit side, input logic [W-1:0] r0, input logic [W-1:0] r1,
                     input logic [SW-1:0] sh, input logic [W-1:0] exp, input string tag);
    issue(side, r0, r1, sh);
    tick();
    if (!side) begin
      chk({tag, "_vld"}, 32'(a_if.res_valid), 32'd1);
      chk(tag, 32'(a_if.res), 32'(exp));
    end else begin
      chk({tag, "_vld"}, 32'(b_if.res_valid), 32'd1);
      chk(tag, 32'(b_if.res), 32'(exp));
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    a_if.valid = 1'b0; a_if.r0 = '0; a_if.r1 = '0; a_if.shift = '0; a_if.res_ready = 1'b1;
    b_if.valid = 1'b0; b_if.r0 = '0; b_if.r1 = '0; b_if.shift = '0; b_if.res_ready = 1'b1;
    tick();
    a_if.valid = 1'b1;
    #1;
    chk("ready_in_reset", 32'(a_if.ready), 32'd0);
    tick();
    a_if.valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("rst_a_vld", 32'(a_if.res_valid), 32'd0);
    chk("rst_b_vld", 32'(b_if.res_valid), 32'd0);
    chk("rst_a_res", 32'(a_if.res), 32'd0);
    chk("rst_b_res", 32'(b_if.res), 32'd0);
    chk("rst_a_rdy", 32'(a_if.ready), 32'd0);
    chk("rst_b_rdy", 32'(b_if.ready), 32'd0);

    // Basic A transaction with latency checks
    issue(1'b0, 18'd3, 18'd5, 5'd0);
    chk("calc_a_vld", 32'(a_if.res_valid), 32'd0);
    chk("calc_a_rdy", 32'(a_if.ready), 32'd0);
    tick();
    chk("a15_vld", 32'(a_if.res_valid), 32'd1);
    chk("a15_res", 32'(a_if.res), 32'd15);
    chk("a15_b_vld", 32'(b_if.res_valid), 32'd0);
    tick();
    chk("a15_drained", 32'(a_if.res_valid), 32'd0);
    chk("a15_kept", 32'(a_if.res), 32'd15);

    // Arithmetic corners
    run(1'b1, 18'h3FFFE, 18'd3,     5'd0,  18'h3FFFA, "b_neg");
    run(1'b0, 18'h20000, 18'h20000, 5'd17, 18'h20000, "a_sh17");
    run(1'b0, 18'h20000, 18'h20000, 5'd31, 18'h00008, "a_sh31");
    run(1'b1, 18'h3FFFE, 18'd3,     5'd20, 18'h0FFFF, "b_sh20_zfill");

    // Tie right after reset: A, then B, then A
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    a_if.valid = 1'b1; a_if.r0 = 18'd3; a_if.r1 = 18'd5;     a_if.shift = 5'd0;
    b_if.valid = 1'b1; b_if.r0 = 18'd7; b_if.r1 = 18'h3FFFF; b_if.shift = 5'd0;
    #1;
    chk("tie1_a_rdy", 32'(a_if.ready), 32'd1);
    chk("tie1_b_rdy", 32'(b_if.ready), 32'd0);
    tick();
    chk("tie_calc_a_rdy", 32'(a_if.ready), 32'd0);
    chk("tie_calc_b_rdy", 32'(b_if.ready), 32'd0);
    tick();
    chk("tie_a_res", 32'(a_if.res), 32'd15);
    chk("tie2_b_rdy", 32'(b_if.ready), 32'd1);
    chk("tie2_a_rdy", 32'(a_if.ready), 32'd0);
    tick();
    chk("tie_a_consumed", 32'(a_if.res_valid), 32'd0);
    tick();
    chk("tie_b_vld", 32'(b_if.res_valid), 32'd1);
    chk("tie_b_res", 32'(b_if.res), 32'h3FFF9);
    chk("tie3_a_rdy", 32'(a_if.ready), 32'd1);
    chk("tie3_b_rdy", 32'(b_if.ready), 32'd0);
    b_if.valid = 1'b0;
    tick();
    a_if.valid = 1'b0;
    tick();
    chk("tie_a_again", 32'(a_if.res_valid), 32'd1);
    tick();

    // Backpressure: A result held while B waits
    a_if.res_ready = 1'b0;
    issue(1'b0, 18'd100, 18'd1000, 5'd0);
    b_if.valid = 1'b1; b_if.r0 = 18'd9; b_if.r1 = 18'd9; b_if.shift = 5'd0;
    #1;
    chk("bp_calc_b_rdy", 32'(b_if.ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_a_vld", 32'(a_if.res_valid), 32'd1);
      chk("bp_a_res", 32'(a_if.res), 32'h186A0);
      chk("bp_b_rdy", 32'(b_if.ready), 32'd0);
      tick();
    end
    a_if.res_ready = 1'b1;
    #1;
    chk("bp_release_b_rdy", 32'(b_if.ready), 32'd1);
    tick();
    b_if.valid = 1'b0;
    chk("bp_a_drained", 32'(a_if.res_valid), 32'd0);
    chk("bp_a_kept", 32'(a_if.res), 32'h186A0);
    chk("bp_b_not_yet", 32'(b_if.res_valid), 32'd0);
    tick();
    chk("bp_b_vld", 32'(b_if.res_valid), 32'd1);
    chk("bp_b_res", 32'(b_if.res), 32'h51);
    tick();

    // Reset while the multiply is in flight
    issue(1'b0, 18'd2, 18'd2, 5'd0);
    reset = 1'b1;
    tick();
    chk("rcalc_a_vld", 32'(a_if.res_valid), 32'd0);
    chk("rcalc_a_res", 32'(a_if.res), 32'd0);
    chk("rcalc_b_res", 32'(b_if.res), 32'd0);
    chk("rcalc_b_vld", 32'(b_if.res_valid), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("rcalc_no_late_vld", 32'(a_if.res_valid), 32'd0);
    run(1'b0, 18'd3, 18'd3, 5'd0, 18'd9, "post_reset_a");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one signed multiply-and-shift unit (the team's `mulxx` multiplier) between two requesters.
- Port A is the CPU execute stage; port B is the coprocessor/DMA side.
- Requesters use a valid/ready handshake; a round-robin arbiter grants them.
- Operands are registered, and each result is held in an output register until the owning requester accepts it.

Parameters:
- WORD_SIZE, 18, data word width; also the width of the operands and the result.
- SHIFT_W, 5, width of the shift field; legal values 0..31.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  arbiter accepts A this cycle.
- a_r0, a_r1  in  WORD_SIZE each  A operands, signed two's complement.
- a_shift  in  SHIFT_W  A right-shift amount.
- a_res_valid  out  1  result for A is available.
- a_res_ready  in  1  A consumes the result.
- a_res  out  WORD_SIZE  A result.
- b_valid, b_ready, b_r0, b_r1, b_shift, b_res_valid, b_res_ready, b_res: identical roles to the A ports, for requester B.

Behaviour:
- Reset values:
  - Both res_valid = 0, both res = 0, both ready = 0.
  - State = IDLE.
  - last_grant = B, so A wins the first tie.
- States: IDLE, CALC, HOLD.
- IDLE:
  - a_ready and b_ready are combinational and mutually exclusive. They depend on the valids, last_grant and the state, and never on ready inputs.
  - Only A valid: a_ready = 1. Only B valid: b_ready = 1.
  - Both valid: grant the side that is not last_grant.
  - Handshake (valid & ready): latch r0, r1, shift and the owner id; update last_grant; go to CALC.
- CALC (exactly one cycle):
  - The multiplier computes combinationally from the latched operands.
  - The result is registered into the owner's res register; the owner's res_valid is set; go to HOLD.
  - Both ready = 0.
- HOLD:
  - Owner res_valid stays 1 and its res stays stable until owner res_ready = 1.
  - On that edge: clear res_valid.
  - Same cycle as the consume, the arbiter may grant a new request; ready may assert in HOLD only when the owner res_ready = 1 that cycle. If granted, go to CALC, otherwise go to IDLE.
  - res_ready from the non-owner is ignored.
- Latency:
  - Accept at edge N; res_valid = 1 after edge N+1.
  - Back-to-back throughput: one result per 2 cycles.
- Arithmetic:
  - res = bits [shift+WORD_SIZE-1 : shift] of the 2*WORD_SIZE-bit signed product, logically shifted.
  - Bits above the product MSB are zero-filled.
  - Shift values up to 31 are legal; there is no saturation or rounding.
- res register: each port's res holds its last value after consumption. It is overwritten only by a new result for that port.
- Requester contract: a requester must not drop valid or change operands before ready is seen. If it does, the arbiter simply does not grant it; no error is flagged.
- Reset mid-operation: any CALC/HOLD transaction is discarded; all outputs return to their reset values on the next edge.
- Simultaneous events:
  - A consume and a new grant in the same cycle are both honoured.
  - Reset dominates everything.

Decomposition:
- Package mul_pkg:
  - WORD_SIZE and SHIFT_W defaults.
  - state_t enum {IDLE, CALC, HOLD}.
  - req_id_t enum {REQ_A, REQ_B}.
- Sub-module: one `mulxx` instance as the shared datapath, fed from the operand registers.
- Arbitration and the FSM are inline.

Test Plan:
- Reset, then A: r0=3, r1=5, shift=0, res_ready=1.
  - a_ready at cycle 0; a_res = 15 with a_res_valid one cycle later; b_res_valid stays 0.
- Signed: B sends r0=0x3FFFE (-2), r1=3, shift=0.
  - b_res = 0x3FFFA.
- Shift: A sends r0=r1=0x20000 (-131072), shift=17.
  - a_res = 0x20000.
- Tie after reset: A and B valid in the same cycle, both res_ready=1.
  - A is granted first, then B, then A again on a continued tie (alternation).
- Backpressure: A result pending with a_res_ready=0 for 5 cycles while B is valid.
  - a_res stays stable; b_ready = 0 throughout.
  - a_res_ready=1 → b_ready=1 in the same cycle; B's result appears 1 cycle later.
- Reset asserted in CALC:
  - No res_valid ever rises for that transaction; the next edge shows reset values.
